// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix engine sequencer: opcodes, instruction
// field positions and the sequencer state encoding.
package matrix_pkg;

    localparam logic [7:0] OP_ADD   = 8'h01;
    localparam logic [7:0] OP_SUB   = 8'h02;
    localparam logic [7:0] OP_MUL   = 8'h03;
    localparam logic [7:0] OP_SCALE = 8'h04;
    localparam logic [7:0] OP_TRANS = 8'h05;
    localparam logic [7:0] OP_STOP  = 8'hFF;

    localparam int unsigned FIELD_W  = 8;
    localparam int unsigned OPC_LSB  = 24;
    localparam int unsigned SRC1_LSB = 16;
    localparam int unsigned SRC2_LSB = 8;
    localparam int unsigned DEST_LSB = 0;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StIssue,
        StExec,
        StHalt
    } seq_state_t;

endpackage

// File: rtl/matrix_inst_decode.sv
// Combinational instruction decoder: splits the instruction register into its
// fields and classifies the opcode as a legal operation or the stop marker.
module matrix_inst_decode
    import matrix_pkg::*;
#(
    parameter logic [7:0] STOP_OPCODE = OP_STOP
) (
    input  logic [31:0] i_ir,
    output logic [7:0]  o_opcode,
    output logic [7:0]  o_src1,
    output logic [7:0]  o_src2,
    output logic [7:0]  o_dest,
    output logic        o_legal,
    output logic        o_stop
);

    assign o_opcode = i_ir[OPC_LSB +: FIELD_W];
    assign o_src1   = i_ir[SRC1_LSB +: FIELD_W];
    assign o_src2   = i_ir[SRC2_LSB +: FIELD_W];
    assign o_dest   = i_ir[DEST_LSB +: FIELD_W];

    // Stop takes priority so a stop opcode is never treated as an operation.
    assign o_stop  = (o_opcode == STOP_OPCODE);
    assign o_legal = (o_opcode >= OP_ADD) && (o_opcode <= OP_TRANS) && !o_stop;

endmodule

// File: rtl/matrix_sequencer.sv
// Instruction sequencer for the matrix engine: fetch, decode, issue, wait.
// Optional retire counter enabled by defining SEQ_RETIRE_COUNT_EN.
module matrix_sequencer
    import matrix_pkg::*;
#(
    parameter int         ADDR_W      = 4,
    parameter int         DEPTH       = 16,
    parameter logic [7:0] STOP_OPCODE = 8'hFF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_inst_enable,
    output logic [ADDR_W-1:0] o_inst_address,
    input  logic [31:0]       i_inst_data,
    output logic              o_op_valid,
    input  logic              i_op_ready,
    output logic [7:0]        o_op_code,
    output logic [7:0]        o_op_src1,
    output logic [7:0]        o_op_src2,
    output logic [7:0]        o_op_dest,
    input  logic              i_op_done,
    output logic              o_busy,
    output logic              o_halted,
    output logic              o_error
`ifdef SEQ_RETIRE_COUNT_EN
    ,
    output logic [7:0]        o_retire_count
`endif
);

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(DEPTH - 1);

    seq_state_t        r_state, w_state_next;
    logic [ADDR_W-1:0] r_pc, w_pc_next;
    logic [31:0]       r_ir;
    logic              r_error, w_error_next;
    logic [7:0]        r_op_code, r_op_src1, r_op_src2, r_op_dest;
    logic [7:0]        w_dec_opcode, w_dec_src1, w_dec_src2, w_dec_dest;
    logic              w_dec_legal, w_dec_stop;
    logic              w_op_valid, w_start_accept, w_idle_or_halt;

    matrix_inst_decode #(
        .STOP_OPCODE (STOP_OPCODE)
    ) u_decode (
        .i_ir     (r_ir),
        .o_opcode (w_dec_opcode),
        .o_src1   (w_dec_src1),
        .o_src2   (w_dec_src2),
        .o_dest   (w_dec_dest),
        .o_legal  (w_dec_legal),
        .o_stop   (w_dec_stop)
    );

    assign w_idle_or_halt = (r_state == StIdle) || (r_state == StHalt);
    assign w_start_accept = i_start && w_idle_or_halt;
    assign w_op_valid     = (r_state == StIssue) && w_dec_legal;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_pc      <= '0;
            r_ir      <= '0;
            r_error   <= 1'b0;
            r_op_code <= '0;
            r_op_src1 <= '0;
            r_op_src2 <= '0;
            r_op_dest <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_error <= w_error_next;
            if (r_state == StLatch) begin
                r_ir <= i_inst_data;
            end
            // Remember the issued fields so they hold once OpValid drops.
            if (w_op_valid) begin
                r_op_code <= w_dec_opcode;
                r_op_src1 <= w_dec_src1;
                r_op_src2 <= w_dec_src2;
                r_op_dest <= w_dec_dest;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_error_next = r_error;
        unique case (r_state)
            StIdle, StHalt: begin
                if (i_start) begin
                    w_pc_next    = '0;
                    w_error_next = 1'b0;
                    w_state_next = StFetch;
                end
            end
            StFetch: w_state_next = StLatch;
            StLatch: w_state_next = StIssue;
            StIssue: begin
                if (w_dec_stop) begin
                    w_state_next = StHalt;
                end else if (!w_dec_legal) begin
                    w_error_next = 1'b1;
                    w_state_next = StHalt;
                end else if (i_op_ready) begin
                    w_state_next = StExec;
                end
            end
            StExec: begin
                if (i_op_done) begin
                    if (r_pc == LAST_PC) begin
                        w_state_next = StHalt;
                    end else begin
                        w_pc_next    = r_pc + ADDR_W'(1);
                        w_state_next = StFetch;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign o_inst_enable  = (r_state == StFetch) || (r_state == StLatch);
    assign o_inst_address = r_pc;
    assign o_op_valid     = w_op_valid;
    assign o_op_code      = w_op_valid ? w_dec_opcode : r_op_code;
    assign o_op_src1      = w_op_valid ? w_dec_src1   : r_op_src1;
    assign o_op_src2      = w_op_valid ? w_dec_src2   : r_op_src2;
    assign o_op_dest      = w_op_valid ? w_dec_dest   : r_op_dest;
    assign o_busy         = !w_idle_or_halt;
    assign o_halted       = (r_state == StHalt);
    assign o_error        = r_error;

`ifdef SEQ_RETIRE_COUNT_EN
    logic [7:0] r_retire_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_retire_count <= '0;
        end else if (w_start_accept) begin
            r_retire_count <= '0;
        end else if ((r_state == StExec) && i_op_done && (r_retire_count != 8'hFF)) begin
            r_retire_count <= r_retire_count + 8'd1;
        end
    end

    assign o_retire_count = r_retire_count;
`endif

endmodule
